// File: rtl/matrix_op_sequencer.sv
// Matrix-op sequencer: walks element indices (and the inner k loop for MMUL) for
// one matrix opcode per start, emitting register-file addresses and ALU/acc strobes.
module matrix_op_sequencer #(
  parameter int IDXW = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [5:0]          op_i,
  input  logic [1:0]          rin1_i,
  input  logic [1:0]          rin2_i,
  input  logic [1:0]          rout_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  output logic [1:0]          rd_sel1_o,
  output logic [1:0]          rd_sel2_o,
  output logic                scalar_sel_o,
  output logic [2*IDXW-1:0]   rd_addr1_o,
  output logic [2*IDXW-1:0]   rd_addr2_o,
  output logic [1:0]          wr_sel_o,
  output logic [2*IDXW-1:0]   wr_addr_o,
  output logic                wr_en_o,
  output logic [1:0]          alu_op_o,
  output logic                acc_clr_o,
  output logic                acc_en_o,
  output logic                cmp_clr_o,
  output logic                cmp_en_o
);
  localparam int AW = 2 * IDXW;
  localparam logic [5:0] OP_MADD = 6'b001000;
  localparam logic [5:0] OP_MSUB = 6'b001001;
  localparam logic [5:0] OP_MMUL = 6'b001100;
  localparam logic [5:0] OP_SMUL = 6'b001101;
  localparam logic [5:0] OP_MCMP = 6'b011000;
  localparam logic [5:0] OP_ZERO = 6'b100100;
  localparam logic [1:0] SEL_BAD = 2'b11;
  localparam logic [AW-1:0]   ELEM_ONE  = AW'(1);
  localparam logic [AW-1:0]   ELEM_LAST = {AW{1'b1}};
  localparam logic [IDXW-1:0] K_ONE     = IDXW'(1);
  localparam logic [IDXW-1:0] K_LAST    = {IDXW{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ELEM = 2'd1,
    S_MAC  = 2'd2,
    S_MWB  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   elem_q, elem_d;
  logic [IDXW-1:0] k_q, k_d;
  logic [5:0]      op_q, op_d;
  logic [1:0]      rin1_q, rin1_d, rin2_q, rin2_d, rout_q, rout_d;
  logic            done_q, done_d, err_q, err_d;

  // Only the selects an opcode actually uses are checked; MMUL may not overwrite a source.
  function automatic logic req_legal(input logic [5:0] op, input logic [1:0] a,
                                     input logic [1:0] b, input logic [1:0] d);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_MADD, OP_MSUB: ok = (a != SEL_BAD) && (b != SEL_BAD) && (d != SEL_BAD);
      OP_MMUL:          ok = (a != SEL_BAD) && (b != SEL_BAD) && (d != SEL_BAD)
                             && (d != a) && (d != b);
      OP_SMUL:          ok = (a != SEL_BAD) && (d != SEL_BAD);
      OP_MCMP:          ok = (a != SEL_BAD) && (b != SEL_BAD);
      OP_ZERO:          ok = (d != SEL_BAD);
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      elem_q  <= '0;
      k_q     <= '0;
      op_q    <= 6'b000000;
      rin1_q  <= 2'b00;
      rin2_q  <= 2'b00;
      rout_q  <= 2'b00;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      k_q     <= k_d;
      op_q    <= op_d;
      rin1_q  <= rin1_d;
      rin2_q  <= rin2_d;
      rout_q  <= rout_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    elem_d  = elem_q;
    k_d     = k_q;
    op_d    = op_q;
    rin1_d  = rin1_q;
    rin2_d  = rin2_q;
    rout_d  = rout_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        elem_d = '0;
        k_d    = '0;
        if (start_i) begin
          if (req_legal(op_i, rin1_i, rin2_i, rout_i)) begin
            op_d    = op_i;
            rin1_d  = rin1_i;
            rin2_d  = rin2_i;
            rout_d  = rout_i;
            state_d = (op_i == OP_MMUL) ? S_MAC : S_ELEM;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ELEM: begin
        elem_d = elem_q + ELEM_ONE;
        if (elem_q == ELEM_LAST) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = S_ELEM;
        end
      end
      S_MAC: begin
        if (k_q == K_LAST) begin
          k_d     = '0;
          state_d = S_MWB;
        end else begin
          k_d     = k_q + K_ONE;
          state_d = S_MAC;
        end
      end
      S_MWB: begin
        elem_d = elem_q + ELEM_ONE;
        if (elem_q == ELEM_LAST) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = S_MAC;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode only registered state, so input changes never reach them combinationally.
  always_comb begin
    busy_o       = (state_q != S_IDLE);
    done_o       = done_q;
    err_o        = err_q;
    rd_sel1_o    = 2'b00;
    rd_sel2_o    = 2'b00;
    scalar_sel_o = 1'b0;
    rd_addr1_o   = '0;
    rd_addr2_o   = '0;
    wr_sel_o     = 2'b00;
    wr_addr_o    = '0;
    wr_en_o      = 1'b0;
    alu_op_o     = 2'b00;
    acc_clr_o    = 1'b0;
    acc_en_o     = 1'b0;
    cmp_clr_o    = 1'b0;
    cmp_en_o     = 1'b0;
    if (state_q != S_IDLE) begin
      rd_sel1_o = rin1_q;
      rd_sel2_o = rin2_q;
      wr_sel_o  = rout_q;
    end else begin
      rd_sel1_o = 2'b00;
    end
    case (state_q)
      S_ELEM: begin
        rd_addr1_o = elem_q;
        rd_addr2_o = elem_q;
        wr_addr_o  = elem_q;
        case (op_q)
          OP_MADD: begin wr_en_o = 1'b1; alu_op_o = 2'b00; end
          OP_MSUB: begin wr_en_o = 1'b1; alu_op_o = 2'b01; end
          OP_SMUL: begin wr_en_o = 1'b1; alu_op_o = 2'b10; scalar_sel_o = 1'b1; end
          OP_ZERO: begin wr_en_o = 1'b1; alu_op_o = 2'b11; end
          OP_MCMP: begin cmp_en_o = 1'b1; cmp_clr_o = (elem_q == '0); end
          default: wr_en_o = 1'b0;
        endcase
      end
      S_MAC: begin
        rd_addr1_o = {elem_q[AW-1:IDXW], k_q};
        rd_addr2_o = {k_q, elem_q[IDXW-1:0]};
        alu_op_o   = 2'b10;
        acc_en_o   = 1'b1;
        acc_clr_o  = (k_q == '0);
      end
      S_MWB: begin
        wr_en_o   = 1'b1;
        wr_addr_o = elem_q;
      end
      default: wr_en_o = 1'b0;
    endcase
  end
endmodule

// File: doc/matrix_op_sequencer.md
# matrix_op_sequencer

Multi-cycle sequencer that steps the matrix datapath through one element-level operation per cycle for the matrix opcodes MADD, MSUB, MMUL, SMUL, MCMP and ZERO. It sits between instruction decode and the matrix register file / ALU / accumulator. It accepts one opcode with register selects per start pulse and emits per-cycle read/write addresses and ALU/accumulator strobes until the operation completes. Scalar opcodes (I*, J*) and MLD/MSTR are not handled here.

## Interface
- IDXW, 2, index width; matrix dimension N = 2**IDXW (legal 1..3)
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only when busy=0
- op  in  6  opcode: MADD 001000, MSUB 001001, MMUL 001100, SMUL 001101, MCMP 011000, ZERO 100100
- RIn1, RIn2, ROut  in  2 each  matrix register select: 00 D1, 01 D2, 10 D3; 11 illegal
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle rejection pulse
- rd_sel1, rd_sel2  out  2 each  operand register selects
- scalar_sel  out  1  operand 2 taken from scalar register (SMUL)
- rd_addr1, rd_addr2  out  2*IDXW each  element address {row,col}
- wr_sel  out  2  destination register; wr_addr  out  2*IDXW; wr_en  out  1
- alu_op  out  2  00 add, 01 sub, 10 mul, 11 pass-zero
- acc_clr, acc_en  out  1 each  accumulator control (MMUL)
- cmp_clr, cmp_en  out  1 each  compare-flag control (MCMP)

## Operation
- Selects and op latched on accepted start; later input changes do not affect the run.
- States: IDLE, ELEM, MAC, MWB.
- IDLE: start=1 with legal request -> ELEM (MADD/MSUB/SMUL/MCMP/ZERO) or MAC (MMUL). Illegal request -> stay IDLE, err=1 next cycle.
- Illegal: op not listed; any used select =11; MMUL with ROut equal to RIn1 or RIn2. Unused selects are ignored (ZERO uses ROut only; MCMP has no ROut; SMUL has no RIn2).
- ELEM: counters (row,col) row-major, col fastest, from {0,0}. One element per cycle. rd_addr1=rd_addr2=wr_addr={row,col}. After {N-1,N-1} -> IDLE.
  - MADD alu_op 00, MSUB 01, SMUL 10 with scalar_sel=1, ZERO 11; wr_en=1, wr_sel=ROut.
  - MCMP: wr_en=0, cmp_en=1 every cycle, cmp_clr=1 on the first cycle only.
- MAC (MMUL): per element (row,col), k runs 0..N-1. rd_addr1={row,k}, rd_addr2={k,col}, alu_op 10, acc_en=1, acc_clr=1 when k=0. After k=N-1 -> MWB.
- MWB: wr_en=1, wr_addr={row,col}, wr_sel=ROut, acc_en=0. Then advance (row,col) and return to MAC, or go to IDLE after {N-1,N-1}.
- rd_sel1=RIn1 and rd_sel2=RIn2 throughout a run.
- All strobes are 0 outside active states. Addresses and selects are 0 in IDLE.
- Arithmetic and width: counters wrap naturally at N; no element data passes through this block.

## Timing
- Outputs are decoded from registered state and counters only. There is no combinational input-to-output path.
- Reset: every output 0, state IDLE, counters 0. rst mid-run aborts immediately: no done, no further wr_en.
- Start accepted at edge of cycle 0 -> first active cycle is 1.
- Elementwise ops: busy=1 in cycles 1..N*N; done=1 and busy=0 in cycle N*N+1.
- MMUL: active cycles 1..N*N*(N+1); done in the following cycle.
- Read and write are same-cycle in ELEM: combinational read, write at the closing edge.
- MMUL write lands one cycle after the last MAC for that element.
- start while busy=1: ignored, not queued.
- start in the same cycle as done: accepted; busy=1 next cycle.
- rst and start together: rst wins.
- err is a one-cycle pulse; busy stays 0.

## Test plan
- MADD RIn1=00 RIn2=01 ROut=10, IDXW=2, start at cycle 0 -> busy cycles 1–16; wr_en 1–16 with wr_addr 0..15 ascending; alu_op=00; wr_sel=10; done at 17; datapath model gives D3=D1+D2.
- MMUL D1=identity, D2=A, ROut=10 -> cycles 1–4 acc_en with rd_addr1={0,k} and rd_addr2={k,0}; acc_clr at 1; wr_en at 5, addr 0; done at 81; D3==A.
- MMUL ROut=00 RIn1=00 -> err=1 at cycle 1; busy, wr_en and done stay 0.
- MSUB running, second start (ZERO) at cycle 5 -> ignored; 16 writes all alu_op=01; single done at 17.
- rst at cycle 8 of MADD -> cycle 9 all outputs 0, no done; start at 10 runs a full 16-write sequence, done at 27.
- ZERO ROut=01 -> 16 writes, alu_op=11, wr_sel=01. MCMP -> wr_en never 1; cmp_en 1–16; cmp_clr only at 1. Illegal op 111111 -> err pulse only.
